if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Holds the PC and drives the instruction-memory address; the memory may insert wait states.
- Owns the IF/ID pipeline register. Its instr_o[31:26] feeds the ID-stage decoder opcode input directly.
- Honours a load-use stall from the hazard unit and a taken-branch redirect resolved downstream; counts delivered instructions.

---
 rtl/if_stage.sv | 71 +++++++
 tb/tb_if_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction-memory request and the IF/ID pipeline register.
// Priority per edge is redirect, then stall, then memory ready, otherwise a wait-state bubble.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic [31:0] fetch_cnt_o
);

  logic        r_started;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;
  logic [31:0] r_fetch_cnt;
  logic [31:0] w_pc_next4;

  assign w_pc_next4  = r_pc + 32'd4;
  assign imem_addr_o = r_pc;
  assign pc_o        = r_pc;
  // A stalled cycle issues no request unless a redirect overrides the stall.
  assign imem_req_o  = r_started & (redirect_i | ~stall_i);

  assign instr_o     = r_instr;
  assign pc_plus4_o  = r_pc_plus4;
  assign valid_o     = r_valid;
  assign fetch_cnt_o = r_fetch_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_started   <= 1'b0;
      r_pc        <= RESET_PC;
      r_instr     <= NOP_INSTR;
      r_pc_plus4  <= 32'h0000_0000;
      r_valid     <= 1'b0;
      r_fetch_cnt <= 32'h0000_0000;
    end else if (!r_started) begin
      r_started <= 1'b1;
    end else if (redirect_i) begin
      r_pc    <= {redirect_pc_i[31:2], 2'b00};
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (stall_i) begin
      // Hold everything; any ready response this cycle is refetched later.
      r_pc <= r_pc;
    end else if (imem_ready_i) begin
      r_instr     <= imem_data_i;
      r_pc_plus4  <= w_pc_next4;
      r_valid     <= 1'b1;
      r_pc        <= w_pc_next4;
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end else begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a reference model pushes expected IF/ID contents into a
// scoreboard when a fetch is accepted, and they are popped and compared after the edge.
module tb_if_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_data_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;
  logic [31:0] fetch_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pp4;
  } sb_t;
  sb_t sb_q[$];

  logic        m_started;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pp4;
  logic        m_deliver;

  if_stage dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ready_i (imem_ready_i),
    .imem_data_i  (imem_data_i),
    .pc_o         (pc_o),
    .instr_o      (instr_o),
    .pc_plus4_o   (pc_plus4_o),
    .valid_o      (valid_o),
    .fetch_cnt_o  (fetch_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h8C01_0004;
      32'h0000_0004: mem_word = 32'h0022_1820;
      32'h0000_0008: mem_word = 32'h1000_FFFF;
      default:       mem_word = {a[15:0], ~a[31:16]} ^ 32'h5A5A_0001;
    endcase
  endfunction

  assign imem_data_i = mem_word(imem_addr_o);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_pc      = 32'h0000_0000;
    m_cnt     = 32'h0000_0000;
    m_valid   = 1'b0;
    m_instr   = 32'h0000_0000;
    m_pp4     = 32'h0000_0000;
    sb_q.delete();
  endtask

  // Drive one cycle of inputs, check combinational outputs, clock, then check registered outputs.
  task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
    sb_t e;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    imem_ready_i  = rdy;
    #1;
    check("imem_req", {31'd0, imem_req_o}, {31'd0, m_started & (rd | ~st)});
    check("imem_addr", imem_addr_o, m_pc);
    m_deliver = 1'b0;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (rd) begin
      m_pc    = {rpc[31:2], 2'b00};
      m_valid = 1'b0;
      m_instr = 32'h0000_0000;
    end else if (st) begin
      m_pc = m_pc;
    end else if (rdy) begin
      sb_q.push_back('{instr: mem_word(m_pc), pp4: m_pc + 32'd4});
      m_pc      = m_pc + 32'd4;
      m_cnt     = m_cnt + 32'd1;
      m_valid   = 1'b1;
      m_deliver = 1'b1;
    end else begin
      m_valid = 1'b0;
      m_instr = 32'h0000_0000;
    end
    @(posedge clk_i);
    #1;
    check("pc", pc_o, m_pc);
    check("valid", {31'd0, valid_o}, {31'd0, m_valid});
    check("fetch_cnt", fetch_cnt_o, m_cnt);
    if (m_deliver) begin
      if (sb_q.size() == 0) begin
        check("sb_empty", 32'd0, 32'd1);
      end else begin
        e       = sb_q.pop_front();
        m_instr = e.instr;
        m_pp4   = e.pp4;
      end
    end
    check("instr", instr_o, m_instr);
    check("pc_plus4", pc_plus4_o, m_pp4);
  endtask

  initial begin
    rst_i         = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    imem_ready_i  = 1'b1;
    model_reset();
    #3;
    check("rst_pc", pc_o, 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_cnt", fetch_cnt_o, 32'h0);
    check("rst_req", {31'd0, imem_req_o}, 32'd0);
    #19 rst_i = 1'b1;

    // Startup then first fetch, two stall cycles, then three more fetches.
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("first_word", instr_o, 32'h8C01_0004);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    check("stall_held", instr_o, 32'h8C01_0004);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("pc_0x10", pc_o, 32'h10);

    // Three wait states at pc 0x10, delivery on the fourth edge.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);

    // Redirect with simultaneous stall; low address bits dropped.
    cyc(1, 1, 32'h0000_0043, 1);
    check("redir_pc", pc_o, 32'h40);
    cyc(0, 0, 0, 1);
    check("redir_pp4", pc_plus4_o, 32'h44);

    // PC wrap at the top of the address space.
    cyc(0, 1, 32'hFFFF_FFFE, 1);
    cyc(0, 0, 0, 1);
    check("wrap_pp4", pc_plus4_o, 32'h0);

    // Async reset in the middle of a wait state at pc 0x20.
    cyc(0, 1, 32'h0000_0020, 0);
    cyc(0, 0, 0, 0);
    #2 rst_i = 1'b0;
    #1;
    check("arst_pc", pc_o, 32'h0);
    check("arst_instr", instr_o, 32'h0);
    check("arst_pp4", pc_plus4_o, 32'h0);
    check("arst_valid", {31'd0, valid_o}, 32'd0);
    check("arst_cnt", fetch_cnt_o, 32'h0);
    check("arst_req", {31'd0, imem_req_o}, 32'd0);
    model_reset();
    @(posedge clk_i);
    #4 rst_i = 1'b1;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Random mix of stalls, wait states and occasional redirects.
    for (int i = 0; i < 200; i++) begin
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
          $urandom, ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
